// File: rtl/axi4_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// axi4_lite_reg_slave
//
// AXI4-Lite subordinate that terminates all five channels and implements a
// bank of NUM_REGS read/write registers with byte strobes. AW and W may be
// accepted in either order or together. Addresses outside the bank, below
// BASE_ADDR, or not aligned to DATA/8 return SLVERR and never modify state.
// The register contents are exported flat on reg_out for downstream logic.
//
// Parameters:
//   ADDR       address width in bits
//   DATA       data width in bits (32 or 64)
//   NUM_REGS   number of registers (1..256)
//   BASE_ADDR  byte address of register 0, aligned to DATA/8
//
// Ports:
//   system_clock        sole clock
//   reset_n             synchronous, active-low reset
//   AW*/W*/B*           write address / write data / write response channels
//   AR*/R*              read address / read data channels
//   reg_out             register i at bits [i*DATA +: DATA]
// ---------------------------------------------------------------------------
module axi4_lite_reg_slave #(
    parameter int              ADDR      = 32,
    parameter int              DATA      = 32,
    parameter int              NUM_REGS  = 16,
    parameter logic [ADDR-1:0] BASE_ADDR = '0
) (
    input  logic                     system_clock,
    input  logic                     reset_n,
    // write address channel
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [ADDR-1:0]          AWADDR,
    input  logic [1:0]               AWPROT,
    // write data channel
    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic [DATA-1:0]          WDATA,
    input  logic [DATA/8-1:0]        WSTRB,
    // write response channel
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [1:0]               BRESP,
    // read address channel
    input  logic                     ARVALID,
    output logic                     ARREADY,
    input  logic [ADDR-1:0]          ARADDR,
    input  logic [1:0]               ARPROT,
    // read data channel
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [DATA-1:0]          RDATA,
    output logic [1:0]               RRESP,
    // register contents
    output logic [NUM_REGS*DATA-1:0] reg_out
);

    localparam int STRB = DATA / 8;
    localparam int LSB  = $clog2(STRB);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_RESP} r_state_e;

    // PROT is accepted but has no effect on this block.
    logic unused_prot;
    assign unused_prot = ^{AWPROT, ARPROT};

    // Valid = at/above base, lane-aligned, and inside the register bank.
    function automatic logic addr_ok(input logic [ADDR-1:0] a);
        logic [ADDR-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && (a[LSB-1:0] == '0) &&
               ((off >> LSB) < ADDR'(NUM_REGS));
    endfunction

    function automatic logic [ADDR-1:0] addr_idx(input logic [ADDR-1:0] a);
        return (a - BASE_ADDR) >> LSB;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    // live_q is low for the cycle(s) reset is sampled, so the READY outputs
    // (decoded from state) are held low during reset and rise in the first
    // cycle after release without any path from reset_n to the outputs.
    logic                live_q;

    w_state_e            w_state_q, w_state_d;
    logic [ADDR-1:0]     awaddr_q,  awaddr_d;
    logic [DATA-1:0]     wdata_q,   wdata_d;
    logic [STRB-1:0]     wstrb_q,   wstrb_d;
    logic [1:0]          bresp_q,   bresp_d;

    r_state_e            r_state_q, r_state_d;
    logic [DATA-1:0]     rdata_q,   rdata_d;
    logic [1:0]          rresp_q,   rresp_d;

    logic [DATA-1:0]     regs_q [NUM_REGS];
    logic [DATA-1:0]     regs_d [NUM_REGS];

    // -----------------------------------------------------------------------
    // Outputs: registered or decoded from state only
    // -----------------------------------------------------------------------
    assign AWREADY = live_q && (w_state_q == W_IDLE || w_state_q == W_DATA);
    assign WREADY  = live_q && (w_state_q == W_IDLE || w_state_q == W_ADDR);
    assign BVALID  = (w_state_q == W_RESP);
    assign BRESP   = bresp_q;

    assign ARREADY = live_q && (r_state_q == R_IDLE);
    assign RVALID  = (r_state_q == R_RESP);
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
            assign reg_out[gi*DATA +: DATA] = regs_q[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Write path
    // -----------------------------------------------------------------------
    logic            aw_hs, w_hs;
    logic            wr_en;
    logic [ADDR-1:0] wr_addr;
    logic [DATA-1:0] wr_data;
    logic [STRB-1:0] wr_strb;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID  && WREADY;

    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        wr_en     = 1'b0;
        wr_addr   = AWADDR;
        wr_data   = WDATA;
        wr_strb   = WSTRB;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_en     = 1'b1;
                    w_state_d = W_RESP;
                end else if (aw_hs) begin
                    awaddr_d  = AWADDR;
                    w_state_d = W_ADDR;
                end else if (w_hs) begin
                    wdata_d   = WDATA;
                    wstrb_d   = WSTRB;
                    w_state_d = W_DATA;
                end
            end
            W_ADDR: begin
                // address held; data arrives live on the W channel
                if (w_hs) begin
                    wr_en     = 1'b1;
                    wr_addr   = awaddr_q;
                    w_state_d = W_RESP;
                end
            end
            W_DATA: begin
                // data held; address arrives live on the AW channel
                if (aw_hs) begin
                    wr_en     = 1'b1;
                    wr_data   = wdata_q;
                    wr_strb   = wstrb_q;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        if (wr_en) begin
            bresp_d = addr_ok(wr_addr) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Register bank next value: only strobed lanes of a valid target change.
    always_comb begin
        logic [ADDR-1:0] idx;
        logic            ok;
        idx = addr_idx(wr_addr);
        ok  = addr_ok(wr_addr);
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && ok && idx == ADDR'(i)) begin
                for (int b = 0; b < STRB; b++) begin
                    if (wr_strb[b]) begin
                        regs_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read path (samples regs_q, so a same-edge write is not yet visible)
    // -----------------------------------------------------------------------
    logic            ar_hs;
    logic [DATA-1:0] rd_sel;
    logic [ADDR-1:0] rd_idx;

    assign ar_hs  = ARVALID && ARREADY;
    assign rd_idx = addr_idx(ARADDR);

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == ADDR'(i)) begin
                rd_sel = regs_q[i];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    if (addr_ok(ARADDR)) begin
                        rdata_d = rd_sel;
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge system_clock) begin
        if (!reset_n) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_reg_slave
//
// Directed bench for axi4_lite_reg_slave (32-bit data, 16 registers, base
// 0x1000). A vector table covers single read/write transactions; hand-written
// sequences cover W-before-AW, backpressure, same-edge read/write and
// mid-transaction reset.
// ---------------------------------------------------------------------------
module tb_axi4_lite_reg_slave;

    localparam int          ADDR     = 32;
    localparam int          DATA     = 32;
    localparam int          NUM_REGS = 16;
    localparam logic [31:0] BASE     = 32'h0000_1000;

    logic                     system_clock = 1'b0;
    logic                     reset_n;
    logic                     AWVALID, AWREADY;
    logic [ADDR-1:0]          AWADDR;
    logic [1:0]               AWPROT;
    logic                     WVALID, WREADY;
    logic [DATA-1:0]          WDATA;
    logic [DATA/8-1:0]        WSTRB;
    logic                     BVALID, BREADY;
    logic [1:0]               BRESP;
    logic                     ARVALID, ARREADY;
    logic [ADDR-1:0]          ARADDR;
    logic [1:0]               ARPROT;
    logic                     RVALID, RREADY;
    logic [DATA-1:0]          RDATA;
    logic [1:0]               RRESP;
    logic [NUM_REGS*DATA-1:0] reg_out;

    always #5 system_clock = ~system_clock;

    axi4_lite_reg_slave #(
        .ADDR     (ADDR),
        .DATA     (DATA),
        .NUM_REGS (NUM_REGS),
        .BASE_ADDR(BASE)
    ) dut (
        .system_clock(system_clock),
        .reset_n     (reset_n),
        .AWVALID     (AWVALID),
        .AWREADY     (AWREADY),
        .AWADDR      (AWADDR),
        .AWPROT      (AWPROT),
        .WVALID      (WVALID),
        .WREADY      (WREADY),
        .WDATA       (WDATA),
        .WSTRB       (WSTRB),
        .BVALID      (BVALID),
        .BREADY      (BREADY),
        .BRESP       (BRESP),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .ARADDR      (ARADDR),
        .ARPROT      (ARPROT),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .reg_out     (reg_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge system_clock);
        #1;
    endtask

    // Simultaneous AW+W; returns the sample taken one cycle after handshake.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic bv);
        int n;
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        n = 0;
        while (!(AWREADY && WREADY) && n < 10) begin
            tick;
            n++;
        end
        check("write_ready_timeout", {511'b0, AWREADY && WREADY}, 512'd1);
        tick;
        AWVALID = 1'b0; WVALID = 1'b0;
        bv   = BVALID;
        resp = BRESP;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [1:0] resp,
                           output logic [31:0] data, output logic rv);
        int n;
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        n = 0;
        while (!ARREADY && n < 10) begin
            tick;
            n++;
        end
        check("read_ready_timeout", {511'b0, ARREADY}, 512'd1);
        tick;
        ARVALID = 1'b0;
        rv   = RVALID;
        data = RDATA;
        resp = RRESP;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        int          idx;   // register to inspect after a write, -1 = none
        logic [31:0] exp;   // read data, or register value after a write
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [1:0]   resp;
        logic [31:0]  data;
        logic         vld;
        logic [511:0] exp_regs;

        vecs[0]  = '{1'b1, BASE + 32'h04, 32'hDEAD_BEEF, 4'hF, 2'b00,  1, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, BASE + 32'h04, 32'h0,         4'h0, 2'b00, -1, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, BASE + 32'h00, 32'hFFFF_FFFF, 4'hF, 2'b00,  0, 32'hFFFF_FFFF};
        vecs[3]  = '{1'b1, BASE + 32'h08, 32'h0000_0001, 4'hF, 2'b00,  2, 32'h0000_0001};
        vecs[4]  = '{1'b1, BASE + 32'h40, 32'h1111_1111, 4'hF, 2'b10, -1, 32'h0};
        vecs[5]  = '{1'b1, BASE + 32'h02, 32'h2222_2222, 4'hF, 2'b10, -1, 32'h0};
        vecs[6]  = '{1'b1, BASE - 32'h04, 32'h3333_3333, 4'hF, 2'b10, -1, 32'h0};
        vecs[7]  = '{1'b0, BASE + 32'h40, 32'h0,         4'h0, 2'b10, -1, 32'h0};
        vecs[8]  = '{1'b0, BASE + 32'h00, 32'h0,         4'h0, 2'b00, -1, 32'hFFFF_FFFF};
        vecs[9]  = '{1'b1, BASE + 32'h3C, 32'hAABB_CCDD, 4'h0, 2'b00, 15, 32'h0};
        vecs[10] = '{1'b0, BASE + 32'h3C, 32'h0,         4'h0, 2'b00, -1, 32'h0};
        vecs[11] = '{1'b1, BASE + 32'h3C, 32'hAABB_CCDD, 4'hA, 2'b00, 15, 32'hAA00_CC00};
        vecs[12] = '{1'b0, BASE + 32'h3C, 32'h0,         4'h0, 2'b00, -1, 32'hAA00_CC00};
        vecs[13] = '{1'b0, BASE + 32'h01, 32'h0,         4'h0, 2'b10, -1, 32'h0};

        reset_n = 1'b0;
        AWVALID = 0; AWADDR = 0; AWPROT = 0;
        WVALID = 0; WDATA = 0; WSTRB = 0; BREADY = 0;
        ARVALID = 0; ARADDR = 0; ARPROT = 0; RREADY = 0;

        // ---- reset state ----
        tick; tick;
        check("rst_awready", {511'b0, AWREADY}, 512'd0);
        check("rst_wready",  {511'b0, WREADY},  512'd0);
        check("rst_arready", {511'b0, ARREADY}, 512'd0);
        check("rst_bvalid",  {511'b0, BVALID},  512'd0);
        check("rst_rvalid",  {511'b0, RVALID},  512'd0);
        check("rst_rdata",   {480'b0, RDATA},   512'd0);
        check("rst_reg_out", reg_out,           512'd0);
        reset_n = 1'b1;
        tick;
        check("rel_ready", {509'b0, AWREADY, WREADY, ARREADY}, 512'd7);

        // ---- vector table ----
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, vld);
                $display("vec %0d: WRITE addr=%08h data=%08h strb=%h -> bvalid=%0d bresp=%0d",
                         i, vecs[i].addr, vecs[i].data, vecs[i].strb, vld, resp);
                check($sformatf("vec%0d_bvalid", i), {511'b0, vld}, 512'd1);
                check($sformatf("vec%0d_bresp", i), {510'b0, resp}, {510'b0, vecs[i].resp});
                if (vecs[i].idx >= 0)
                    check($sformatf("vec%0d_reg", i), {480'b0, reg_out[vecs[i].idx*32 +: 32]},
                          {480'b0, vecs[i].exp});
                tick;
                check($sformatf("vec%0d_bdone", i), {511'b0, BVALID}, 512'd0);
            end else begin
                do_read(vecs[i].addr, resp, data, vld);
                $display("vec %0d: READ  addr=%08h -> rvalid=%0d rdata=%08h rresp=%0d",
                         i, vecs[i].addr, vld, data, resp);
                check($sformatf("vec%0d_rvalid", i), {511'b0, vld}, 512'd1);
                check($sformatf("vec%0d_rresp", i), {510'b0, resp}, {510'b0, vecs[i].resp});
                check($sformatf("vec%0d_rdata", i), {480'b0, data}, {480'b0, vecs[i].exp});
                tick;
                check($sformatf("vec%0d_rdone", i), {511'b0, RVALID}, 512'd0);
            end
        end

        exp_regs = '0;
        exp_regs[0*32 +: 32]  = 32'hFFFF_FFFF;
        exp_regs[1*32 +: 32]  = 32'hDEAD_BEEF;
        exp_regs[2*32 +: 32]  = 32'h0000_0001;
        exp_regs[15*32 +: 32] = 32'hAA00_CC00;
        check("table_reg_out", reg_out, exp_regs);

        // ---- W three cycles ahead of AW, partial strobe ----
        WDATA = 32'h1234_5678; WSTRB = 4'h5; WVALID = 1'b1; BREADY = 1'b1;
        tick;
        WVALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("wfirst_wready_low", {511'b0, WREADY}, 512'd0);
            check("wfirst_awready_hi", {511'b0, AWREADY}, 512'd1);
            check("wfirst_no_bvalid", {511'b0, BVALID}, 512'd0);
            if (c < 2) tick;
        end
        AWADDR = BASE; AWVALID = 1'b1;
        tick;
        AWVALID = 1'b0;
        $display("seq wfirst: bvalid=%0d bresp=%0d reg0=%08h", BVALID, BRESP, reg_out[31:0]);
        check("wfirst_bvalid", {511'b0, BVALID}, 512'd1);
        check("wfirst_bresp",  {510'b0, BRESP},  512'd0);
        check("wfirst_reg0",   {480'b0, reg_out[31:0]}, {480'b0, 32'hFF34_FF78});
        tick;

        // ---- backpressure: BREADY/RREADY low for 5 cycles ----
        AWADDR = BASE + 32'h0C; WDATA = 32'h0000_0055; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        tick;
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp_bvalid", {511'b0, BVALID}, 512'd1);
            check("bp_bresp",  {510'b0, BRESP},  512'd0);
            check("bp_wready", {510'b0, AWREADY, WREADY}, 512'd0);
            tick;
        end
        $display("seq bpress write: bvalid=%0d reg3=%08h", BVALID, reg_out[3*32 +: 32]);
        BREADY = 1'b1;
        tick;
        check("bp_bdone", {511'b0, BVALID}, 512'd0);
        check("bp_awready", {511'b0, AWREADY}, 512'd1);

        ARADDR = BASE + 32'h0C; ARVALID = 1'b1; RREADY = 1'b0;
        tick;
        ARVALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp_rvalid",  {511'b0, RVALID},  512'd1);
            check("bp_rdata",   {480'b0, RDATA},   {480'b0, 32'h0000_0055});
            check("bp_rresp",   {510'b0, RRESP},   512'd0);
            check("bp_arready", {511'b0, ARREADY}, 512'd0);
            tick;
        end
        $display("seq bpress read: rvalid=%0d rdata=%08h", RVALID, RDATA);
        RREADY = 1'b1;
        tick;
        check("bp_rdone", {511'b0, RVALID}, 512'd0);
        check("bp_arready_back", {511'b0, ARREADY}, 512'd1);

        // ---- same-edge read and write of reg2 ----
        AWADDR = BASE + 32'h08; WDATA = 32'h2; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        ARADDR = BASE + 32'h08; ARVALID = 1'b1; RREADY = 1'b1;
        tick;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        $display("seq same-edge: rdata=%08h reg2=%08h", RDATA, reg_out[2*32 +: 32]);
        check("same_rvalid", {511'b0, RVALID}, 512'd1);
        check("same_rdata_old", {480'b0, RDATA}, 512'd1);
        check("same_bvalid", {511'b0, BVALID}, 512'd1);
        check("same_reg2", {480'b0, reg_out[2*32 +: 32]}, 512'd2);
        tick;
        do_read(BASE + 32'h08, resp, data, vld);
        $display("seq same-edge reread: rdata=%08h", data);
        check("same_rdata_new", {480'b0, data}, 512'd2);
        tick;

        // ---- reset while in W_ADDR and R_RESP ----
        AWADDR = BASE + 32'h10; AWVALID = 1'b1; BREADY = 1'b1;
        ARADDR = BASE + 32'h00; ARVALID = 1'b1; RREADY = 1'b0;
        tick;
        AWVALID = 1'b0; ARVALID = 1'b0;
        check("mid_waddr", {510'b0, AWREADY, WREADY}, 512'd1);
        check("mid_rvalid", {511'b0, RVALID}, 512'd1);
        reset_n = 1'b0;
        tick;
        check("mid_rst_rvalid", {511'b0, RVALID}, 512'd0);
        check("mid_rst_bvalid", {511'b0, BVALID}, 512'd0);
        check("mid_rst_ready", {509'b0, AWREADY, WREADY, ARREADY}, 512'd0);
        check("mid_rst_rdata", {480'b0, RDATA}, 512'd0);
        check("mid_rst_regs", reg_out, 512'd0);
        tick;
        reset_n = 1'b1;
        RREADY = 1'b1;
        tick;
        check("mid_rel_ready", {509'b0, AWREADY, WREADY, ARREADY}, 512'd7);
        WDATA = 32'h0; WVALID = 1'b1;
        tick;
        // stray W goes to W_DATA; without a pending AW nothing must respond
        WVALID = 1'b0;
        check("mid_no_bvalid", {511'b0, BVALID}, 512'd0);
        AWADDR = BASE + 32'h40; AWVALID = 1'b1;
        tick;
        AWVALID = 1'b0;
        check("mid_stray_slverr", {510'b0, BRESP}, 512'd2);
        tick;
        do_write(BASE + 32'h10, 32'hCAFE_F00D, 4'hF, resp, vld);
        $display("seq post-reset write: bvalid=%0d bresp=%0d reg4=%08h", vld, resp, reg_out[4*32 +: 32]);
        check("post_bvalid", {511'b0, vld}, 512'd1);
        check("post_bresp", {510'b0, resp}, 512'd0);
        exp_regs = '0;
        exp_regs[4*32 +: 32] = 32'hCAFE_F00D;
        check("post_reg_out", reg_out, exp_regs);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi4_lite_reg_slave.md
# axi4_lite_reg_slave

Parametrised AXI4-Lite subordinate that terminates all five AXI4-Lite channels and implements a bank of `NUM_REGS` read/write registers. It is the next-generation endpoint behind the `axi4_lite_if` bus: generic in address width, data width, register count and base address, with byte strobes, independent AW/W acceptance order and SLVERR decoding. Register contents are exported as a flat vector for downstream logic. It serves as the DUT for the UVC and as a reusable CSR block.

## Interface
Parameters:
- `ADDR`, 32, address width in bits.
- `DATA`, 32, data width in bits; legal values 32 or 64.
- `NUM_REGS`, 16, number of registers; range 1..256.
- `BASE_ADDR`, 0, byte address of register 0; aligned to `DATA/8`.

Ports:
- `system_clock`  in  1  sole clock.
- `reset_n`  in  1  reset, synchronous and active-low.
- `AWVALID` in 1 / `AWREADY` out 1 / `AWADDR` in ADDR / `AWPROT` in 2: write address channel.
- `WVALID` in 1 / `WREADY` out 1 / `WDATA` in DATA / `WSTRB` in DATA/8: write data channel.
- `BVALID` out 1 / `BREADY` in 1 / `BRESP` out 2: write response channel.
- `ARVALID` in 1 / `ARREADY` out 1 / `ARADDR` in ADDR / `ARPROT` in 2: read address channel.
- `RVALID` out 1 / `RREADY` in 1 / `RDATA` out DATA / `RRESP` out 2: read data channel.
- `reg_out`  out  NUM_REGS*DATA  register `i` occupies bits `[i*DATA +: DATA]`.

## Operation
- Decode: `idx = (addr - BASE_ADDR) >> log2(DATA/8)`. An address is valid when `addr >= BASE_ADDR`, it is aligned to `DATA/8`, and `idx < NUM_REGS`. Invalid addresses produce SLVERR (2'b10); valid ones produce OKAY (2'b00). `*PROT` is ignored.
- Write FSM states: `W_IDLE`, `W_ADDR` (AW held), `W_DATA` (W held), `W_RESP`.
  - `AWREADY` = state ∈ {IDLE, DATA}; `WREADY` = state ∈ {IDLE, ADDR}.
  - IDLE: AW and W handshaking in the same cycle → write, then RESP. AW alone → ADDR. W alone → DATA.
  - ADDR: W handshake → write, then RESP. DATA: AW handshake → write, then RESP.
  - Write commit: lane `b` of `reg[idx]` updates only when `WSTRB[b]` is set. A valid address with `WSTRB == 0` returns OKAY and changes nothing. An invalid address changes nothing.
  - RESP: `BVALID` = 1 with the latched `BRESP`. On `BVALID && BREADY` → IDLE.
- Read FSM states: `R_IDLE`, `R_RESP`. `ARREADY` = (state == IDLE).
  - On AR handshake, `RDATA` and `RRESP` are registered and the FSM moves to RESP. An invalid address returns `RDATA` = 0 with SLVERR.
  - `RVALID` holds in RESP, with `RDATA`/`RRESP` stable, until `RREADY` is seen → IDLE.
- Read and write channels are fully independent. A read and a write to the same register on the same edge: the read returns the pre-write value.
- Reset (synchronous, any state, including mid-transaction): every register clears to 0, both FSMs return to IDLE, and pending transactions are dropped with no response.

## Timing
- Reset values: `BVALID`, `RVALID`, `BRESP`, `RRESP`, `RDATA`, `reg_out` = 0.
- `AWREADY`, `WREADY`, `ARREADY` are 0 while `reset_n` = 0. They are 1 in the first cycle after release.
- Write latency: `BVALID` rises exactly 1 cycle after the later of the AW and W handshakes. `reg_out` shows the new value in that same cycle.
- Read latency: `RVALID` rises exactly 1 cycle after the AR handshake.
- Back-to-back throughput: one write per 2 cycles (handshake + response with `BREADY` = 1), and likewise one read per 2 cycles.
- All outputs are registered, or decoded only from FSM state. There are no combinational paths from input to output.
- Once `BVALID`/`RVALID` is asserted, it is never withdrawn before its handshake, and payload outputs stay stable.

## Test plan
- Reset then simultaneous AW/W to `BASE_ADDR+4`, `WDATA`=0xDEADBEEF, `WSTRB`=0xF, `BREADY`=1 → `BVALID` 1 cycle later with OKAY; `reg_out[63:32]`=0xDEADBEEF; a read of the same address returns 0xDEADBEEF with OKAY, `RVALID` 1 cycle after AR.
- W issued 3 cycles before AW (addr `BASE_ADDR+0`, data 0x12345678, `WSTRB`=0x5) onto reg0=0xFFFFFFFF → `WREADY` low after the W handshake, `AWREADY` still high; result reg0=0xFF34FF78, OKAY.
- Write to `BASE_ADDR+NUM_REGS*4`, to an unaligned address `+2`, and read of an out-of-range address → SLVERR on each; all registers unchanged; `RDATA`=0.
- `BREADY`/`RREADY` held low 5 cycles → `BVALID`/`RVALID` and payload stable throughout; `AWREADY`/`WREADY`/`ARREADY` stay 0 until the handshake.
- Same-edge read and write to reg2 (old 0x1, new 0x2) → read returns 0x1; a subsequent read returns 0x2.
- `reset_n` pulsed low while in `W_ADDR` and in `R_RESP` → no `BVALID`; `RVALID` drops; all registers are 0; a fresh write afterwards completes normally.
